// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, LSB first, with start bit, optional parity
// and one or two stop bits. A one-entry holding register in front of the shift
// register lets back-to-back frames go out with no idle bit between them.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY_EN != 0);
    localparam logic       ODD_PARITY = (PARITY_ODD != 0);

    state_t                 state;
    logic [DATA_BITS-1:0]   hold;
    logic                   hold_full;
    logic [DATA_BITS-1:0]   shreg;
    logic [3:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   parity_bit;
    logic                   load_now;
    logic                   accept;

    // The holding register is empty exactly when a new word may be accepted.
    assign din_ready = ~hold_full;
    assign accept    = din_valid & ~hold_full;

    // A held word moves into the shifter on a tick when idle, or on the tick
    // that ends the last stop bit so the next start bit follows immediately.
    assign load_now = baud_tick & hold_full &
                      ((state == IDLE) || ((state == STOP) && (stop_cnt == STOP_LAST)));

    // Capture the client word on handshake, independent of the baud tick.
    // NOTE: data-only registers are left out of reset; hold_full guards their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= din;
        end
    end

    // Frame sequencer: all line outputs and the holding flag are registered here.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_full  <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                hold_full <= 1'b1;
            end

            if (baud_tick) begin
                unique case (state)
                    IDLE: ;
                    START: begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (HAS_PARITY) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PARITY: begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (stop_cnt == STOP_LAST) begin
                            done  <= 1'b1;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // NOTE: this later assignment deliberately overrides the STOP-to-IDLE
            // values above when a held word is waiting.
            if (load_now) begin
                shreg      <= hold;
                hold_full  <= 1'b0;
                parity_bit <= (^hold) ^ ODD_PARITY;
                tx         <= 1'b0;
                busy       <= 1'b1;
                state      <= START;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: five transmitters with different frame formats share one tick and
// data bus; each line is compared once per bit period against an expected bit
// stream built from the frame format rules.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int NI = 5;
    localparam int CFG_DB [NI] = '{8, 8, 8, 8, 5};
    localparam int CFG_PE [NI] = '{0, 1, 1, 0, 1};
    localparam int CFG_PO [NI] = '{0, 0, 1, 0, 1};
    localparam int CFG_SB [NI] = '{1, 1, 1, 2, 2};

    typedef struct packed {
        logic val;
        logic first;
        logic last;
    } bit_t;

    logic          clk;
    logic          reset;
    logic          baud_tick = 1'b0;
    logic [7:0]    din;
    logic [NI-1:0] din_valid;
    logic [NI-1:0] rdy, tx, busy, done;

    int   tick_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt [NI] = '{default: 0};
    int   busy_cnt [NI] = '{default: 0};

    bit_t q [NI][$];
    int   pending [NI];
    logic prev_last [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .DATA_BITS (CFG_DB[g]),
            .PARITY_EN (CFG_PE[g]),
            .PARITY_ODD(CFG_PO[g]),
            .STOP_BITS (CFG_SB[g])
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .baud_tick(baud_tick),
            .din      (din[CFG_DB[g]-1:0]),
            .din_valid(din_valid[g]),
            .din_ready(rdy[g]),
            .tx       (tx[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clk baud tick every 16 clocks, changed on the falling edge.
    always @(negedge clk) begin
        tick_cnt  = (tick_cnt == 15) ? 0 : tick_cnt + 1;
        baud_tick = (tick_cnt == 0);
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (done[k] === 1'b1) done_cnt[k]++;
            if (busy[k] === 1'b1) busy_cnt[k]++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic int frame_len(input int k);
        return 1 + CFG_DB[k] + CFG_PE[k] + CFG_SB[k];
    endfunction

    // Expected line contents for one word: start, data LSB first, parity, stops.
    function automatic void push_frame(input int k, input logic [7:0] w);
        int   n    = frame_len(k);
        int   ones = 0;
        bit_t e;
        for (int j = 0; j < CFG_DB[k]; j++) ones += int'(w[j]);
        for (int i = 0; i < n; i++) begin
            e.first = (i == 0);
            e.last  = (i == n - 1);
            if (i == 0)                                       e.val = 1'b0;
            else if (i <= CFG_DB[k])                          e.val = w[i-1];
            else if (CFG_PE[k] != 0 && i == CFG_DB[k] + 1)    e.val = ((ones % 2) != (CFG_PO[k] % 2));
            else                                              e.val = 1'b1;
            q[k].push_back(e);
        end
    endfunction

    function automatic logic any_queued();
        for (int k = 0; k < NI; k++) if (q[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NI; k++) begin
            q[k].delete();
            pending[k]   = 0;
            prev_last[k] = 1'b0;
        end
    endfunction

    task automatic align();
        do @(posedge clk); while (!baud_tick);
        @(negedge clk);
    endtask

    // One bit period: wait for a tick, then compare every line to the model.
    task automatic sample_check();
        bit_t e;
        logic eb, ed, er;
        do @(posedge clk); while (!baud_tick);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            ed = prev_last[k];
            if (q[k].size() > 0) begin
                e  = q[k].pop_front();
                eb = 1'b1;
                if (e.first) pending[k]--;
            end else begin
                e  = '{val: 1'b1, first: 1'b0, last: 1'b0};
                eb = 1'b0;
            end
            er           = (pending[k] == 0);
            prev_last[k] = e.last;
            checks += 4;
            if (tx[k] !== e.val) begin
                errors++; $display("FAIL tx inst%0d t=%0t got %b want %b", k, $time, tx[k], e.val);
            end
            if (busy[k] !== eb) begin
                errors++; $display("FAIL busy inst%0d t=%0t got %b want %b", k, $time, busy[k], eb);
            end
            if (done[k] !== ed) begin
                errors++; $display("FAIL done inst%0d t=%0t got %b want %b", k, $time, done[k], ed);
            end
            if (rdy[k] !== er) begin
                errors++; $display("FAIL din_ready inst%0d t=%0t got %b want %b", k, $time, rdy[k], er);
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (any_queued() && guard < 100) begin
            sample_check();
            guard++;
        end
        sample_check();
        checks++;
        if (guard >= 100) begin
            errors++; $display("FAIL drain: frames still queued after %0d bit periods", guard);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [NI-1:0] mask);
        din       = w;
        din_valid = mask;
        @(posedge clk);
        @(negedge clk);
        din_valid = '0;
        din       = 8'($urandom);
        for (int k = 0; k < NI; k++) begin
            if (mask[k]) begin
                push_frame(k, w);
                pending[k]++;
                checks++;
                if (rdy[k] !== 1'b0) begin
                    errors++; $display("FAIL ready_fall inst%0d got %b want 0", k, rdy[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks += 4;
            if (tx[k] !== 1'b1)   begin errors++; $display("FAIL reset_tx inst%0d got %b want 1", k, tx[k]); end
            if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy inst%0d got %b want 0", k, busy[k]); end
            if (done[k] !== 1'b0) begin errors++; $display("FAIL reset_done inst%0d got %b want 0", k, done[k]); end
            if (rdy[k] !== 1'b1)  begin errors++; $display("FAIL reset_ready inst%0d got %b want 1", k, rdy[k]); end
        end
        reset = 1'b0;
        model_clear();
    endtask

    // Send one word everywhere and check busy length and a single done pulse.
    task automatic test_frame(input logic [7:0] w, input string name);
        int b0 [NI];
        int d0 [NI];
        align();
        #1;
        for (int k = 0; k < NI; k++) begin b0[k] = busy_cnt[k]; d0[k] = done_cnt[k]; end
        send(w, '1);
        drain();
        #1;
        for (int k = 0; k < NI; k++) begin
            checks += 2;
            if (busy_cnt[k] - b0[k] !== 16 * frame_len(k)) begin
                errors++; $display("FAIL %s_busy_len inst%0d got %0d want %0d", name, k, busy_cnt[k] - b0[k], 16 * frame_len(k));
            end
            if (done_cnt[k] - d0[k] !== 1) begin
                errors++; $display("FAIL %s_done_cnt inst%0d got %0d want 1", name, k, done_cnt[k] - d0[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b0 [NI];
        int d0 [NI];
        align();
        #1;
        for (int k = 0; k < NI; k++) begin b0[k] = busy_cnt[k]; d0[k] = done_cnt[k]; end
        send(8'h00, '1);
        repeat (3) sample_check();
        send(8'hFF, '1);
        drain();
        #1;
        for (int k = 0; k < NI; k++) begin
            checks += 2;
            if (busy_cnt[k] - b0[k] !== 32 * frame_len(k)) begin
                errors++; $display("FAIL b2b_busy_len inst%0d got %0d want %0d", k, busy_cnt[k] - b0[k], 32 * frame_len(k));
            end
            if (done_cnt[k] - d0[k] !== 2) begin
                errors++; $display("FAIL b2b_done_cnt inst%0d got %0d want 2", k, done_cnt[k] - d0[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0 [NI];
        align();
        send(8'h96, '1);
        sample_check();
        send(8'h33, '1);
        repeat (4) sample_check();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int k = 0; k < NI; k++) begin
            checks += 4;
            if (tx[k] !== 1'b1)   begin errors++; $display("FAIL midreset_tx inst%0d got %b want 1", k, tx[k]); end
            if (busy[k] !== 1'b0) begin errors++; $display("FAIL midreset_busy inst%0d got %b want 0", k, busy[k]); end
            if (rdy[k] !== 1'b1)  begin errors++; $display("FAIL midreset_ready inst%0d got %b want 1", k, rdy[k]); end
            if (done[k] !== 1'b0) begin errors++; $display("FAIL midreset_done inst%0d got %b want 0", k, done[k]); end
        end
        #1;
        for (int k = 0; k < NI; k++) d0[k] = done_cnt[k];
        repeat (3) sample_check();
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (done_cnt[k] !== d0[k]) begin
                errors++; $display("FAIL midreset_no_done inst%0d got %0d want %0d", k, done_cnt[k], d0[k]);
            end
        end
        send(8'h5A, '1);
        drain();
    endtask

    task automatic test_handshake_corners();
        // Valid held while the holding register is full must not overwrite it.
        align();
        send(8'hC3, 5'b00001);
        sample_check();
        send(8'h81, 5'b00001);
        din       = 8'h7E;
        din_valid = 5'b00001;
        repeat (4) sample_check();
        din_valid = '0;
        drain();

        // Handshake on the same edge as an idle tick: start bit waits a tick.
        @(posedge baud_tick);
        din       = 8'h4D;
        din_valid = '1;
        @(posedge clk);
        @(negedge clk);
        din_valid = '0;
        for (int k = 0; k < NI; k++) begin
            checks += 3;
            if (tx[k] !== 1'b1)   begin errors++; $display("FAIL coincident_tx inst%0d got %b want 1", k, tx[k]); end
            if (busy[k] !== 1'b0) begin errors++; $display("FAIL coincident_busy inst%0d got %b want 0", k, busy[k]); end
            if (rdy[k] !== 1'b0)  begin errors++; $display("FAIL coincident_ready inst%0d got %b want 0", k, rdy[k]); end
            push_frame(k, 8'h4D);
            pending[k]++;
        end
        drain();
    endtask

    task automatic test_random();
        logic [NI-1:0] mask;
        for (int it = 0; it < 8; it++) begin
            align();
            mask = NI'($urandom) | NI'(1);
            send(8'($urandom), mask);
            repeat ($urandom_range(1, 6)) sample_check();
            if ($urandom_range(0, 1) == 1) send(8'($urandom), mask);
            drain();
        end
    endtask

    initial begin
        reset     = 1'b1;
        din       = '0;
        din_valid = '0;
        model_clear();
        test_reset();
        test_frame(8'hA5, "basic");
        test_frame(8'h07, "parity");
        test_frame(8'h3C, "two_stop");
        test_back_to_back();
        test_reset_mid();
        test_handshake_corners();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that serialises parallel words onto a single `tx` line, LSB first, with start bit, optional parity and 1 or 2 stop bits. It is the transmit-side counterpart of the team's `uart_rx`, shares the same externally generated `baud_tick` (one tick per bit period), and sits between a byte-producing client (valid/ready handshake) and the UART pin. A one-entry holding register allows back-to-back frames with no idle gap.

## Interface
- `DATA_BITS`, 8, data bits per frame (5–9).
- `PARITY_EN`, 0, 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0, 0 selects even parity and 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1, number of stop bits (1 or 2).

- `clk`  in  1  system clock; the block uses this single clock.
- `reset`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-`clk` pulse per bit period.
- `din`  in  DATA_BITS  word to transmit, sampled on handshake.
- `din_valid`  in  1  client has a word on `din`.
- `din_ready`  out  1  holding register empty; the word is accepted when `din_valid && din_ready` at a `clk` edge.
- `tx`  out  1  serial output; idles high.
- `busy`  out  1  a frame is on the line (start bit through last stop bit).
- `done`  out  1  one-`clk` pulse when the last stop bit of a frame completes.

## Operation
- Storage consists of the holding register `hold` with flag `hold_full`, a shift register, a bit counter and parity.
- `din_ready` = !`hold_full`, driven directly from the register. A handshake sets `hold_full` and captures `din` on any `clk` cycle, independent of `baud_tick`. `din` may change after capture.
- The FSM states are IDLE, START, DATA, PARITY, STOP. Transitions happen only on `clk` edges where `baud_tick`=1. Each non-IDLE state drives its bit for exactly one bit period per bit.
- **IDLE:** `tx`=1 and `busy`=0. On a tick with `hold_full`=1:
  - load the shift register from `hold`, clear `hold_full`, and compute parity (XOR of data bits, inverted if `PARITY_ODD`);
  - set `tx`=0, `busy`=1 and go to START.
- **START:** on a tick, drive data bit 0, set the counter to 0 and go to DATA.
- **DATA:** on a tick, if the counter = DATA_BITS-1, drive parity and go to PARITY when `PARITY_EN`, else drive `tx`=1 and go to STOP. Otherwise drive the next bit (LSB first) and increment the counter.
- **PARITY:** on a tick, drive `tx`=1 and go to STOP.
- **STOP:** lasts `STOP_BITS` ticks. On the final tick, pulse `done`. Then:
  - if `hold_full`, perform the IDLE load action in the same cycle, so `tx`=0 immediately and there is no idle bit;
  - otherwise set `tx`=1, `busy`=0 and go to IDLE.
- Simultaneous events: a handshake and a hold→shift transfer can never occur in the same cycle, because one requires the register empty and the other full. A handshake in the same cycle as an IDLE tick does not start a frame on that tick; the frame starts on the next tick.
- **Reset:** `tx`=1, `busy`=0, `done`=0, `din_ready`=1, state IDLE, `hold_full`=0.
  - Reset mid-frame aborts the frame. `tx` is high on the cycle after reset. Any held word is discarded and no `done` is issued.

## Timing
- All outputs are registered. `tx` changes only on `baud_tick` cycles, except on reset.
- Frame length = 1 + DATA_BITS + PARITY_EN + STOP_BITS bit periods.
- Latency from handshake in IDLE to start-bit edge is from 1 `clk` up to one bit period (the next tick strictly after the handshake).
- `din_ready` falls the cycle after the handshake. It rises the cycle after the hold→shift transfer, which is the start-bit tick.
- `done` is high for exactly 1 `clk` per frame, coincident with the tick that ends the last stop bit.
- `busy` stays high continuously across back-to-back frames.

## Test plan
- **Basic frame:** defaults, tick every 16 `clk`, send 0xA5 → `tx` per bit period is 0,1,0,1,0,0,1,0,1,1; 160 `clk` with `busy`=1; a single `done`; `tx` returns high.
- **Back-to-back:** send 0x00, then 0xFF while the first is in DATA → `din_ready` low until the second start bit. The stop bit of 0x00 is followed immediately by the start bit of 0xFF. `busy` never drops and `done` pulses twice.
- **Parity:** `PARITY_EN`=1, send 0x07 → even config gives parity bit 1, odd config gives 0; frame is 11 bit periods.
- **Two stop bits:** `STOP_BITS`=2, send 0x3C → two high bit periods after data; `done` only at the end of the second.
- **Reset mid-frame:** assert `reset` during data bit 3 with a word held → next cycle `tx`=1, `busy`=0, `din_ready`=1, no `done`. A following 0x5A transmits correctly.
- **Handshake corners:** hold `din_valid`=1 while `din_ready`=0 → no capture. Do a handshake on the same cycle as an IDLE tick → the start bit begins on the following tick, not the coincident one.
